cdc_in_arbiter: RTL and testbench

Round-robin arbiter sharing the single usb_cdc IN byte stream (device-to-host: in_data/in_valid/in_ready) between N application byte-stream requesters. It grants one requester at a time and holds the grant for a whole message, optionally prefixed by a channel-tag header byte. The grant is released on end-of-message, burst cap or inactivity timeout. It sits between the application logic and usb_cdc in the app clock domain.

---
 rtl/cdc_in_arbiter.sv | 108 ++++++++++
 tb/tb_cdc_in_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_in_arbiter.sv
// cdc_in_arbiter: round-robin arbiter sharing the usb_cdc IN byte stream among N requesters
module cdc_in_arbiter #(
    parameter int         N            = 4,
    parameter int         MAX_BURST    = 64,
    parameter bit         HEADER_EN    = 1'b1,
    parameter logic [7:0] HDR_BASE     = 8'hA0,
    parameter int         IDLE_TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [8*N-1:0] req_data_i,
    input  logic [N-1:0]   req_valid_i,
    input  logic [N-1:0]   req_last_i,
    output logic [N-1:0]   req_ready_o,
    output logic [7:0]     in_data_o,
    output logic           in_valid_o,
    input  logic           in_ready_i,
    output logic [N-1:0]   grant_o,
    output logic           busy_o
);
    localparam int SW = $clog2(N);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 2);
    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
    state_t        state;
    logic [SW-1:0] sel, last, pick, idx;
    logic          any_req, slot_free, accept, g_valid, g_last, cap_hit, idle_hit;
    logic [7:0]    g_data;
    logic [BW-1:0] burst_cnt;
    logic [IW-1:0] idle_cnt;
    assign slot_free   = !in_valid_o || in_ready_i;
    assign accept      = state == DATA && g_valid && slot_free;
    assign req_ready_o = (state == DATA && slot_free) ? grant_o : '0;
    assign busy_o      = state != IDLE;
    assign cap_hit     = int'(burst_cnt) + 1 == MAX_BURST;
    assign idle_hit    = IDLE_TIMEOUT != 0 && !g_valid && int'(idle_cnt) + 1 == IDLE_TIMEOUT;
    // Scan from the farthest offset down so the nearest requester after 'last' wins.
    always_comb begin
        pick    = last;
        idx     = '0;
        any_req = 1'b0;
        for (int i = N; i >= 1; i--) begin
            idx = SW'((int'(last) + i) % N);
            if (req_valid_i[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                g_data  = req_data_i[8*k +: 8];
                g_valid = req_valid_i[k];
                g_last  = req_last_i[k];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            sel        <= '0;
            last       <= SW'(N - 1);
            grant_o    <= '0;
            burst_cnt  <= '0;
            idle_cnt   <= '0;
            in_valid_o <= 1'b0;
            in_data_o  <= '0;
        end else begin
            if (state == HEADER && slot_free) begin
                in_data_o  <= HDR_BASE + 8'(sel);
                in_valid_o <= 1'b1;
            end else if (accept) begin
                in_data_o  <= g_data;
                in_valid_o <= 1'b1;
            end else if (in_ready_i) begin
                in_valid_o <= 1'b0;
            end
            case (state)
                IDLE: if (any_req) begin
                    sel       <= pick;
                    grant_o   <= N'(1) << pick;
                    state     <= HEADER_EN ? HEADER : DATA;
                    burst_cnt <= '0;
                    idle_cnt  <= '0;
                end
                HEADER: if (slot_free) state <= DATA;
                DATA: begin
                    if (accept) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        idle_cnt  <= '0;
                    end else if (!g_valid && IDLE_TIMEOUT != 0) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    if ((accept && (g_last || cap_hit)) || idle_hit) begin
                        state   <= IDLE;
                        last    <= sel;
                        grant_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_in_arbiter.sv
// tb_cdc_in_arbiter: queue-driven requesters, transaction-level arbitration model and stream scoreboard
module tb_cdc_in_arbiter;
    localparam int         N  = 4;
    localparam int         MB = 4;
    localparam int         TO = 8;
    localparam logic [7:0] HB = 8'hA0;
    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic [N-1:0]   req_ready_o;
    logic [7:0]     in_data_o;
    logic           in_valid_o;
    logic           in_ready_i = 1'b0;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    int checks = 0;
    int errors = 0;
    logic [8:0] chq [N][$];
    logic [8:0] mq [N][$];
    logic [7:0] exp_q [$];
    int m_last = N - 1;
    int acc_cnt [N];
    logic [N-1:0] fire = '0;
    int rmode = 1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    cdc_in_arbiter #(.N(N), .MAX_BURST(MB), .HEADER_EN(1'b1), .HDR_BASE(HB), .IDLE_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
        .req_last_i(req_last_i), .req_ready_o(req_ready_o), .in_data_o(in_data_o),
        .in_valid_o(in_valid_o), .in_ready_i(in_ready_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected stream from the arbitration rules: rotate from the last owner, send a tag,
    // then bytes until a last flag, the burst cap, or the source runs dry (timeout release).
    function automatic void model_run();
        while (1) begin
            int sel;
            int n;
            sel = -1;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (sel < 0 && mq[c].size() > 0) sel = c;
            end
            if (sel < 0) return;
            exp_q.push_back(HB + 8'(sel));
            n = 0;
            while (1) begin
                logic [8:0] b;
                b = mq[sel].pop_front();
                exp_q.push_back(b[7:0]);
                n++;
                if (b[8] || n == MB || mq[sel].size() == 0) break;
            end
            m_last = sel;
        end
    endfunction

    task automatic load(input int ch, input int len, input bit lst, input logic [7:0] base, input logic [7:0] step);
        for (int j = 0; j < len; j++) begin
            logic [8:0] b;
            b[8]   = lst && j == len - 1;
            b[7:0] = 8'(int'(base) + int'(step) * j);
            chq[ch].push_back(b);
            mq[ch].push_back(b);
        end
    endtask

    function automatic bit chans_busy();
        for (int k = 0; k < N; k++) if (chq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic flush();
        for (int k = 0; k < N; k++) begin
            chq[k].delete();
            mq[k].delete();
        end
        exp_q.delete();
        m_last = N - 1;
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush();
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() > 0 || chans_busy() || busy_o) && t < 3000) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still expected after %0d cycles", name, exp_q.size(), t);
        end
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] g);
        int t;
        t = 0;
        while (grant_o == '0 && t < 200) begin
            tick();
            t++;
        end
        check(name, grant_o, g);
    endtask

    // Requester and sink driver: inputs change on negedge, handshakes are sampled just after.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (fire[k] && chq[k].size() > 0) begin
                void'(chq[k].pop_front());
                acc_cnt[k]++;
            end
        end
        in_ready_i = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : rmode == 2 ? ~in_ready_i : ($urandom_range(0, 9) < 7);
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]         = chq[k].size() > 0;
            req_last_i[k]          = chq[k].size() > 0 ? chq[k][0][8] : 1'b0;
            req_data_i[8*k +: 8]   = chq[k].size() > 0 ? chq[k][0][7:0] : 8'h00;
        end
        #1;
        fire = req_valid_i & req_ready_o;
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            check("grant_onehot", 32'($onehot0(grant_o)), 1);
            if (prev_stall) begin
                check("stall_valid", in_valid_o, 1);
                check("stall_data", in_data_o, prev_data);
            end
            if (in_valid_o && in_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, expected none", in_data_o);
                end else begin
                    check("stream", in_data_o, exp_q.pop_front());
                end
            end
            prev_stall = in_valid_o && !in_ready_i;
            prev_data  = in_data_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a0;
        int t;
        for (int k = 0; k < N; k++) acc_cnt[k] = 0;
        rst_i = 1'b1;
        repeat (2) tick();
        check("rst_in_valid", in_valid_o, 0);
        check("rst_in_data", in_data_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        rst_i = 1'b0;
        tick();
        // single message from ch2
        load(2, 3, 1'b1, 8'h11, 8'h11);
        model_run();
        wait_grant("single_grant", 4'b0100);
        check("single_busy", busy_o, 1);
        drain("single");
        check("single_grant_after", grant_o, 0);
        check("single_busy_after", busy_o, 0);
        // round robin, ch0 again only after ch3
        do_reset();
        for (int k = 0; k < N; k++) load(k, 1, 1'b1, 8'(k), 8'h00);
        load(0, 1, 1'b1, 8'h04, 8'h00);
        model_run();
        drain("rr");
        // backpressure toggling every cycle
        do_reset();
        rmode = 2;
        load(1, 8, 1'b1, 8'h40, 8'h01);
        model_run();
        drain("bp");
        rmode = 1;
        // burst cap with a competing requester
        do_reset();
        load(0, 10, 1'b0, 8'h60, 8'h01);
        load(1, 2, 1'b1, 8'h80, 8'h01);
        model_run();
        drain("cap");
        // inactivity timeout with ch0 waiting
        do_reset();
        a0 = acc_cnt[3];
        load(3, 2, 1'b0, 8'h30, 8'h01);
        model_run();
        wait_grant("to_grant3", 4'b1000);
        load(0, 1, 1'b1, 8'h55, 8'h00);
        model_run();
        t = 0;
        while (acc_cnt[3] != a0 + 2 && t < 200) begin
            tick();
            t++;
        end
        check("to_accepts", acc_cnt[3], a0 + 2);
        repeat (7) tick();
        check("to_held", grant_o, 4'b1000);
        tick();
        check("to_released", grant_o, 0);
        tick();
        check("to_next_grant", grant_o, 4'b0001);
        drain("timeout");
        // reset while a ch1 payload byte is stalled
        do_reset();
        a0 = acc_cnt[1];
        load(1, 4, 1'b1, 8'h70, 8'h01);
        model_run();
        t = 0;
        while (acc_cnt[1] == a0 && t < 200) begin
            tick();
            t++;
        end
        rmode = 0;
        repeat (2) tick();
        check("mid_stalled", in_valid_o, 1);
        rst_i = 1'b1;
        flush();
        tick();
        check("mid_rst_valid", in_valid_o, 0);
        check("mid_rst_grant", grant_o, 0);
        check("mid_rst_busy", busy_o, 0);
        rst_i = 1'b0;
        rmode = 1;
        load(0, 1, 1'b1, 8'hC0, 8'h00);
        load(1, 1, 1'b1, 8'hC1, 8'h00);
        model_run();
        wait_grant("mid_after_grant", 4'b0001);
        drain("mid_after");
        // randomized traffic with random sink backpressure
        rmode = 3;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                int nm;
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) load(k, $urandom_range(1, 9), 1'b1, 8'($urandom), 8'($urandom));
            end
            model_run();
            drain("random");
        end
        rmode = 1;
        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
